// File: rtl/arb_pkg.sv
// Shared types and constants for the memory-port arbiter.
package arb_pkg;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_WAIT = 2'd2
    } arb_state_t;

    // Owner of the transaction currently on the bus.
    localparam logic GNT_IF  = 1'b0;
    localparam logic GNT_MEM = 1'b1;

endpackage : arb_pkg

// File: rtl/arb_select.sv
// Winner selection between fetch and load/store, with a streak counter
// that bounds how many data grants may pass a waiting fetch.
module arb_select
    import arb_pkg::*;
#(
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic if_valid,
    input  logic mem_valid,
    input  logic accept,
    output logic grant,
    output logic if_ready,
    output logic mem_ready
);

    localparam int SW = $clog2(MAX_DATA_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);

    logic [SW-1:0] streak;

    // Pick the winner: data first unless a waiting fetch has been passed too often.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
        grant     = GNT_IF;
        if_ready  = 1'b0;
        mem_ready = 1'b0;
        if (mem_valid && (!if_valid || streak != STREAK_MAX)) begin
            grant = GNT_MEM;
        end
        if (accept) begin
            if_ready  = if_valid  && (grant == GNT_IF);
            mem_ready = mem_valid && (grant == GNT_MEM);
        end
    end

    // Count data grants made while a fetch was waiting; a fetch grant clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            streak <= '0;
        end else if (if_ready) begin
            streak <= '0;
        end else if (mem_ready && if_valid && streak != STREAK_MAX) begin
            streak <= streak + 1'b1;
        end
    end

endmodule : arb_select

// File: rtl/mem_port_arbiter.sv
// Shares one valid/ready memory port between instruction fetch and the
// load/store path: one outstanding transaction, response routed to its owner.
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W          = 64,
    parameter int DATA_W          = 64,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic                clk,
    input  logic                rst,
    // instruction fetch
    input  logic                if_req_valid,
    input  logic [ADDR_W-1:0]   if_req_addr,
    output logic                if_req_ready,
    output logic                if_resp_valid,
    output logic [DATA_W-1:0]   if_resp_data,
    // load/store
    input  logic                mem_req_valid,
    input  logic [ADDR_W-1:0]   mem_req_addr,
    input  logic                mem_req_wen,
    input  logic [DATA_W-1:0]   mem_req_wdata,
    input  logic [DATA_W/8-1:0] mem_req_wmask,
    output logic                mem_req_ready,
    output logic                mem_resp_valid,
    output logic [DATA_W-1:0]   mem_resp_data,
    // memory bus
    output logic                bus_req_valid,
    output logic [ADDR_W-1:0]   bus_req_addr,
    output logic                bus_req_wen,
    output logic [DATA_W-1:0]   bus_req_wdata,
    output logic [DATA_W/8-1:0] bus_req_wmask,
    input  logic                bus_req_ready,
    input  logic                bus_resp_valid,
    input  logic [DATA_W-1:0]   bus_resp_data,
    output logic                busy
);

    arb_state_t state, state_nx;
    logic       grant;
    logic       sel_grant;
    logic       accept;
    logic       take;
    logic       resp_fire;

    // Requests are only offered in IDLE; readies stay low while reset is applied.
    assign accept = (state == ST_IDLE) && !rst;
    assign take   = if_req_ready || mem_req_ready;

    arb_select #(
        .MAX_DATA_STREAK (MAX_DATA_STREAK)
    ) u_select (
        .clk       (clk),
        .rst       (rst),
        .if_valid  (if_req_valid),
        .mem_valid (mem_req_valid),
        .accept    (accept),
        .grant     (sel_grant),
        .if_ready  (if_req_ready),
        .mem_ready (mem_req_ready)
    );

    // Next-state logic: IDLE -> ADDR on accept, ADDR -> WAIT on bus ready, WAIT -> IDLE on response.
    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: if (take)           state_nx = ST_ADDR;
            ST_ADDR: if (bus_req_ready)  state_nx = ST_WAIT;
            ST_WAIT: if (bus_resp_valid) state_nx = ST_IDLE;
            default:                     state_nx = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so all flops update together.
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    // Capture the winning request in the accept cycle and hold it until the next accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant         <= GNT_IF;
            bus_req_addr  <= '0;
            bus_req_wen   <= 1'b0;
            bus_req_wdata <= '0;
            bus_req_wmask <= '0;
        end else if (take) begin
            grant <= sel_grant;
            if (mem_req_ready) begin
                bus_req_addr  <= mem_req_addr;
                bus_req_wen   <= mem_req_wen;
                bus_req_wdata <= mem_req_wdata;
                bus_req_wmask <= mem_req_wmask;
            end else begin
                bus_req_addr  <= if_req_addr;
                bus_req_wen   <= 1'b0;
                bus_req_wdata <= '0;
                bus_req_wmask <= '0;
            end
        end
    end

    // Route a response to its owner; responses outside WAIT are dropped.
    always_comb begin
        resp_fire      = (state == ST_WAIT) && bus_resp_valid;
        if_resp_valid  = resp_fire && (grant == GNT_IF);
        mem_resp_valid = resp_fire && (grant == GNT_MEM);
        if_resp_data   = if_resp_valid  ? bus_resp_data : '0;
        mem_resp_data  = mem_resp_valid ? bus_resp_data : '0;
    end

    assign bus_req_valid = (state == ST_ADDR);
    assign busy          = (state != ST_IDLE);

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a
// randomized run against a rule-level model of grant order and routing.
module tb_mem_port_arbiter;

    localparam int AW   = 64;
    localparam int DW   = 64;
    localparam int MAXS = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req_valid;
    logic [AW-1:0] if_req_addr;
    logic          if_req_ready;
    logic          if_resp_valid;
    logic [DW-1:0] if_resp_data;
    logic          mem_req_valid;
    logic [AW-1:0] mem_req_addr;
    logic          mem_req_wen;
    logic [DW-1:0] mem_req_wdata;
    logic [DW/8-1:0] mem_req_wmask;
    logic          mem_req_ready;
    logic          mem_resp_valid;
    logic [DW-1:0] mem_resp_data;
    logic          bus_req_valid;
    logic [AW-1:0] bus_req_addr;
    logic          bus_req_wen;
    logic [DW-1:0] bus_req_wdata;
    logic [DW/8-1:0] bus_req_wmask;
    logic          bus_req_ready;
    logic          bus_resp_valid;
    logic [DW-1:0] bus_resp_data;
    logic          busy;

    int total = 0;
    int bad   = 0;

    mem_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .MAX_DATA_STREAK(MAXS)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
        .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
        .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask), .mem_req_ready(mem_req_ready),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .bus_req_valid(bus_req_valid), .bus_req_addr(bus_req_addr), .bus_req_wen(bus_req_wen),
        .bus_req_wdata(bus_req_wdata), .bus_req_wmask(bus_req_wmask), .bus_req_ready(bus_req_ready),
        .bus_resp_valid(bus_resp_valid), .bus_resp_data(bus_resp_data), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        if_req_valid   = 1'b0; if_req_addr   = '0;
        mem_req_valid  = 1'b0; mem_req_addr  = '0; mem_req_wen = 1'b0;
        mem_req_wdata  = '0;   mem_req_wmask = '0;
        bus_req_ready  = 1'b0; bus_resp_valid = 1'b0; bus_resp_data = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
        settle();
    endtask

    // Called right after the accept edge: stalls the bus, then raises a response and settles.
    task automatic serve_to_resp(input int rd, input int wd, input logic [DW-1:0] data);
        repeat (rd) tick();
        bus_req_ready = 1'b1;
        tick();
        bus_req_ready = 1'b0;
        repeat (wd) tick();
        bus_resp_valid = 1'b1;
        bus_resp_data  = data;
        settle();
    endtask

    task automatic end_resp();
        tick();
        bus_resp_valid = 1'b0;
        bus_resp_data  = '0;
        settle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        if_req_valid  = 1'b1;
        mem_req_valid = 1'b1;
        tick();
        tick();
        total++;
        if ({if_req_ready, if_resp_valid, mem_req_ready, mem_resp_valid, bus_req_valid, bus_req_wen, busy} !== 7'b0) begin
            bad++;
            $display("FAIL reset_ctrl: got %b want 0000000",
                     {if_req_ready, if_resp_valid, mem_req_ready, mem_resp_valid, bus_req_valid, bus_req_wen, busy});
        end
        total++;
        if ({if_resp_data, mem_resp_data, bus_req_addr, bus_req_wdata, bus_req_wmask} !== '0) begin
            bad++;
            $display("FAIL reset_data: got %h want 0",
                     {if_resp_data, mem_resp_data, bus_req_addr, bus_req_wdata, bus_req_wmask});
        end
        idle_inputs();
        rst = 1'b0;
        settle();
    endtask

    task automatic test_single_fetch();
        do_reset();
        if_req_valid = 1'b1;
        if_req_addr  = 64'h0000_0000_8000_0000;
        settle();
        total++;
        if ({if_req_ready, mem_req_ready} !== 2'b10) begin
            bad++; $display("FAIL fetch_ready: got %b want 10", {if_req_ready, mem_req_ready});
        end
        tick();
        if_req_valid = 1'b0;
        settle();
        total++;
        if ({bus_req_valid, busy, bus_req_addr, bus_req_wen, bus_req_wmask} !== {2'b11, 64'h8000_0000, 1'b0, 8'h00}) begin
            bad++;
            $display("FAIL fetch_bus: got v=%b busy=%b a=%h wen=%b m=%h want v=1 busy=1 a=80000000 wen=0 m=00",
                     bus_req_valid, busy, bus_req_addr, bus_req_wen, bus_req_wmask);
        end
        serve_to_resp(0, 0, 64'h0000_0000_0013_0513);
        total++;
        if ({if_resp_valid, if_resp_data[31:0], mem_resp_valid, mem_resp_data} !== {1'b1, 32'h0013_0513, 1'b0, 64'h0}) begin
            bad++;
            $display("FAIL fetch_resp: got iv=%b id=%h mv=%b md=%h want iv=1 id=00130513 mv=0 md=0",
                     if_resp_valid, if_resp_data[31:0], mem_resp_valid, mem_resp_data);
        end
        end_resp();
        total++;
        if ({if_resp_valid, busy} !== 2'b00) begin
            bad++; $display("FAIL fetch_done: got iv=%b busy=%b want 0 0", if_resp_valid, busy);
        end
    endtask

    task automatic test_store();
        do_reset();
        mem_req_valid = 1'b1;
        mem_req_addr  = 64'h0000_0000_8000_1000;
        mem_req_wen   = 1'b1;
        mem_req_wdata = 64'h1122_3344_5566_7788;
        mem_req_wmask = 8'h0F;
        settle();
        total++;
        if ({if_req_ready, mem_req_ready} !== 2'b01) begin
            bad++; $display("FAIL store_ready: got %b want 01", {if_req_ready, mem_req_ready});
        end
        tick();
        idle_inputs();
        settle();
        total++;
        if ({bus_req_valid, bus_req_wen, bus_req_addr, bus_req_wdata, bus_req_wmask} !==
            {1'b1, 1'b1, 64'h8000_1000, 64'h1122_3344_5566_7788, 8'h0F}) begin
            bad++;
            $display("FAIL store_bus: got v=%b wen=%b a=%h d=%h m=%h want 1 1 80001000 1122334455667788 0f",
                     bus_req_valid, bus_req_wen, bus_req_addr, bus_req_wdata, bus_req_wmask);
        end
        serve_to_resp(1, 1, 64'hdead_beef_0000_0001);
        total++;
        if ({mem_resp_valid, if_resp_valid, if_resp_data} !== {1'b1, 1'b0, 64'h0}) begin
            bad++;
            $display("FAIL store_ack: got mv=%b iv=%b id=%h want 1 0 0", mem_resp_valid, if_resp_valid, if_resp_data);
        end
        end_resp();
        total++;
        if (mem_resp_valid !== 1'b0) begin
            bad++; $display("FAIL store_pulse: got mv=%b want 0", mem_resp_valid);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        if_req_valid  = 1'b1; if_req_addr  = 64'h0000_0000_0000_0400;
        mem_req_valid = 1'b1; mem_req_addr = 64'h0000_0000_0000_2000;
        settle();
        total++;
        if ({if_req_ready, mem_req_ready} !== 2'b01) begin
            bad++; $display("FAIL simul_first: got %b want 01", {if_req_ready, mem_req_ready});
        end
        tick();
        mem_req_valid = 1'b0;
        settle();
        total++;
        if ({if_req_ready, mem_req_ready, bus_req_addr} !== {2'b00, 64'h2000}) begin
            bad++;
            $display("FAIL simul_addr: got rdy=%b a=%h want 00 2000", {if_req_ready, mem_req_ready}, bus_req_addr);
        end
        serve_to_resp(0, 0, 64'h5);
        end_resp();
        total++;
        if ({if_req_ready, mem_req_ready} !== 2'b10) begin
            bad++; $display("FAIL simul_second: got %b want 10", {if_req_ready, mem_req_ready});
        end
        tick();
        if_req_valid = 1'b0;
        settle();
        total++;
        if (bus_req_addr !== 64'h400) begin
            bad++; $display("FAIL simul_fetch_addr: got %h want 400", bus_req_addr);
        end
        serve_to_resp(0, 0, 64'h6);
        total++;
        if (if_resp_valid !== 1'b1) begin
            bad++; $display("FAIL simul_fetch_resp: got %b want 1", if_resp_valid);
        end
        end_resp();
    endtask

    task automatic test_starvation();
        logic [6:0] order;   // 1 = data grant, bit k = k-th grant
        int loads_left;
        order = 7'b1101111;  // D D D D I D D (LSB first)
        loads_left = 6;
        do_reset();
        if_req_valid = 1'b1;
        if_req_addr  = 64'h100;
        for (int k = 0; k < 7; k++) begin
            mem_req_valid = (loads_left > 0);
            mem_req_addr  = 64'(32'h3000 + k * 8);
            settle();
            total++;
            if ({if_req_ready, mem_req_ready} !== {!order[k], order[k]}) begin
                bad++;
                $display("FAIL starve_grant%0d: got %b want %b", k, {if_req_ready, mem_req_ready}, {!order[k], order[k]});
            end
            tick();
            if (mem_req_ready === 1'b0 && order[k]) loads_left = loads_left;
            if (order[k]) loads_left--;
            mem_req_valid = 1'b0;
            serve_to_resp(0, 0, 64'(k));
            end_resp();
        end
        idle_inputs();
    endtask

    task automatic test_stall_spurious();
        do_reset();
        if_req_valid = 1'b1;
        if_req_addr  = 64'h0000_0000_0000_0abc;
        settle();
        tick();
        if_req_valid  = 1'b0;
        mem_req_valid = 1'b1;
        mem_req_addr  = 64'h7777;
        for (int c = 0; c < 5; c++) begin
            bus_resp_valid = (c == 2);
            settle();
            total++;
            if ({bus_req_valid, bus_req_addr, bus_req_wen, if_req_ready, mem_req_ready, if_resp_valid, mem_resp_valid} !==
                {1'b1, 64'habc, 1'b0, 4'b0000}) begin
                bad++;
                $display("FAIL stall_addr%0d: got v=%b a=%h wen=%b rdy=%b rv=%b want 1 abc 0 00 00", c,
                         bus_req_valid, bus_req_addr, bus_req_wen, {if_req_ready, mem_req_ready}, {if_resp_valid, mem_resp_valid});
            end
            tick();
        end
        bus_resp_valid = 1'b0;
        bus_req_ready  = 1'b1;
        tick();
        bus_req_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            settle();
            total++;
            if ({busy, bus_req_valid, if_req_ready, mem_req_ready, if_resp_valid, mem_resp_valid} !== 6'b100000) begin
                bad++;
                $display("FAIL stall_wait%0d: got %b want 100000", c,
                         {busy, bus_req_valid, if_req_ready, mem_req_ready, if_resp_valid, mem_resp_valid});
            end
            tick();
        end
        bus_resp_valid = 1'b1;
        bus_resp_data  = 64'h99;
        settle();
        total++;
        if ({if_resp_valid, mem_resp_valid, if_resp_data} !== {2'b10, 64'h99}) begin
            bad++; $display("FAIL stall_resp: got %b %h want 10 99", {if_resp_valid, mem_resp_valid}, if_resp_data);
        end
        mem_req_valid = 1'b0;
        end_resp();
        bus_resp_valid = 1'b1;
        bus_resp_data  = 64'h55;
        settle();
        total++;
        if ({if_resp_valid, mem_resp_valid, busy} !== 3'b000) begin
            bad++; $display("FAIL spurious_idle: got %b want 000", {if_resp_valid, mem_resp_valid, busy});
        end
        tick();
        bus_resp_valid = 1'b0;
        settle();
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL spurious_state: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        if_req_valid = 1'b1;
        if_req_addr  = 64'h40;
        settle();
        tick();
        if_req_valid  = 1'b0;
        bus_req_ready = 1'b1;
        tick();
        bus_req_ready = 1'b0;
        settle();
        total++;
        if ({busy, bus_req_valid} !== 2'b10) begin
            bad++; $display("FAIL rstmid_wait: got %b want 10", {busy, bus_req_valid});
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        total++;
        if ({if_req_ready, if_resp_valid, mem_req_ready, mem_resp_valid, bus_req_valid, bus_req_wen, busy,
             bus_req_addr, bus_req_wmask} !== '0) begin
            bad++;
            $display("FAIL rstmid_outputs: got ctl=%b a=%h want 0 0",
                     {if_req_ready, if_resp_valid, mem_req_ready, mem_resp_valid, bus_req_valid, bus_req_wen, busy}, bus_req_addr);
        end
        bus_resp_valid = 1'b1;
        bus_resp_data  = 64'h1234;
        settle();
        total++;
        if ({if_resp_valid, mem_resp_valid, if_resp_data} !== {2'b00, 64'h0}) begin
            bad++; $display("FAIL rstmid_late: got %b %h want 00 0", {if_resp_valid, mem_resp_valid}, if_resp_data);
        end
        tick();
        bus_resp_valid = 1'b0;
        if_req_valid = 1'b1;
        if_req_addr  = 64'h80;
        settle();
        total++;
        if ({if_req_ready, busy} !== 2'b10) begin
            bad++; $display("FAIL rstmid_new_ready: got %b want 10", {if_req_ready, busy});
        end
        tick();
        if_req_valid = 1'b0;
        serve_to_resp(0, 0, 64'habcd);
        total++;
        if ({if_resp_valid, if_resp_data, bus_req_addr} !== {1'b1, 64'habcd, 64'h80}) begin
            bad++;
            $display("FAIL rstmid_new_resp: got v=%b d=%h a=%h want 1 abcd 80", if_resp_valid, if_resp_data, bus_req_addr);
        end
        end_resp();
    endtask

    task automatic test_random();
        bit              if_pend, mem_pend, exp_mem;
        int              streak_m;
        logic [AW-1:0]   ia, ma;
        logic            mw;
        logic [DW-1:0]   md, rdata;
        logic [DW/8-1:0] mm;
        int              rd, wd;
        do_reset();
        if_pend  = 0;
        mem_pend = 0;
        streak_m = 0;
        ia = '0; ma = '0; mw = 1'b0; md = '0; mm = '0;
        for (int n = 0; n < 80; n++) begin
            if (!if_pend && $urandom_range(0, 2) != 0) begin
                if_pend = 1; ia = {$urandom, $urandom};
            end
            if (!mem_pend && $urandom_range(0, 2) != 0) begin
                mem_pend = 1; ma = {$urandom, $urandom}; mw = 1'($urandom_range(0, 1));
                md = {$urandom, $urandom}; mm = 8'($urandom);
            end
            if (!if_pend && !mem_pend) begin
                if_pend = 1; ia = {$urandom, $urandom};
            end
            if_req_valid  = if_pend;  if_req_addr   = ia;
            mem_req_valid = mem_pend; mem_req_addr  = ma; mem_req_wen = mw;
            mem_req_wdata = md;       mem_req_wmask = mm;
            settle();
            exp_mem = mem_pend && (!if_pend || streak_m < MAXS);
            total++;
            if ({if_req_ready, mem_req_ready} !== {!exp_mem, exp_mem}) begin
                bad++;
                $display("FAIL rand_grant%0d: got %b want %b streak=%0d", n, {if_req_ready, mem_req_ready},
                         {!exp_mem, exp_mem}, streak_m);
            end
            if (exp_mem) begin
                if (if_pend && streak_m < MAXS) streak_m++;
            end else begin
                streak_m = 0;
            end
            tick();
            if (exp_mem) begin mem_pend = 0; mem_req_valid = 1'b0; end
            else         begin if_pend  = 0; if_req_valid  = 1'b0; end
            settle();
            total++;
            if ({bus_req_valid, bus_req_addr, bus_req_wen, bus_req_wmask} !==
                {1'b1, exp_mem ? ma : ia, exp_mem ? mw : 1'b0, exp_mem ? mm : 8'h00}) begin
                bad++;
                $display("FAIL rand_bus%0d: got v=%b a=%h w=%b m=%h want 1 %h %b %h", n, bus_req_valid, bus_req_addr,
                         bus_req_wen, bus_req_wmask, exp_mem ? ma : ia, exp_mem ? mw : 1'b0, exp_mem ? mm : 8'h00);
            end
            if (exp_mem) begin
                total++;
                if (bus_req_wdata !== md) begin
                    bad++; $display("FAIL rand_wdata%0d: got %h want %h", n, bus_req_wdata, md);
                end
            end
            rd = $urandom_range(0, 3);
            wd = $urandom_range(0, 3);
            for (int c = 0; c < rd; c++) begin
                bus_resp_valid = 1'($urandom_range(0, 1));
                bus_resp_data  = {$urandom, $urandom};
                settle();
                total++;
                if ({if_req_ready, mem_req_ready, if_resp_valid, mem_resp_valid, bus_req_valid} !== 5'b00001) begin
                    bad++;
                    $display("FAIL rand_addr%0d: got %b want 00001", n,
                             {if_req_ready, mem_req_ready, if_resp_valid, mem_resp_valid, bus_req_valid});
                end
                tick();
            end
            bus_resp_valid = 1'b0;
            rdata = {$urandom, $urandom};
            serve_to_resp(0, wd, rdata);
            total++;
            if ({if_resp_valid, if_resp_data, mem_resp_valid, mem_resp_data} !==
                {!exp_mem, exp_mem ? 64'h0 : rdata, exp_mem, exp_mem ? rdata : 64'h0}) begin
                bad++;
                $display("FAIL rand_resp%0d: got iv=%b id=%h mv=%b md=%h data=%h owner_mem=%b", n,
                         if_resp_valid, if_resp_data, mem_resp_valid, mem_resp_data, rdata, exp_mem);
            end
            end_resp();
        end
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_single_fetch();
        test_store();
        test_simultaneous();
        test_starvation();
        test_stall_spurious();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mem_port_arbiter
